// File: rtl/aes_pkg.sv
// Shared types, round constants and the S-box for the AES-128 key schedule.
package aes_pkg;

  typedef logic [0:31]  aes_word_t;
  typedef logic [0:127] aes_block_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } aes_ks_state_t;

  // Entry 0 is unused: round key n is produced with RCON[n].
  localparam logic [7:0] RCON [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion round, purely combinational.
module aes_key_step
  import aes_pkg::*;
(
  input  aes_block_t i_prev,
  input  logic [7:0] i_rcon,
  output aes_block_t o_next
);

  aes_word_t w_w0, w_w1, w_w2, w_w3, w_t;
  aes_word_t w_n0, w_n1, w_n2, w_n3;

  assign w_w0 = i_prev[0:31];
  assign w_w1 = i_prev[32:63];
  assign w_w2 = i_prev[64:95];
  assign w_w3 = i_prev[96:127];

  // SubWord(RotWord(w3)): bytes rotate left by one before substitution.
  assign w_t = {sbox(w_w3[8:15]), sbox(w_w3[16:23]), sbox(w_w3[24:31]), sbox(w_w3[0:7])}
               ^ {i_rcon, 24'h0};

  assign w_n0 = w_w0 ^ w_t;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  assign o_next = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule controller: one round key per clock,
// all 11 keys held in a register file and read by index or as a flat bus.
// Optional build macro AES_KEY_CACHE_EN: re-accepting the key already
// expanded (while in DONE) completes the handshake without re-expanding.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NROUNDS = 10
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           key_valid,
  input  logic [0:127]                   key,
  output logic                           key_ready,
  output logic                           busy,
  output logic                           sched_valid,
  input  logic [3:0]                     rk_idx,
  output logic [0:127]                   rk,
  output logic [0:128*(NROUNDS+1)-1]     schedule
);

  localparam logic [3:0] LAST = 4'(NROUNDS);

  aes_ks_state_t r_state, w_state_nxt;
  logic [3:0]    r_cnt;
  aes_block_t    r_rk [0:NROUNDS];
  logic          r_sched_valid;

  logic          w_accept, w_hit, w_start, w_last;
  logic [3:0]    w_prev_idx;
  aes_block_t    w_step_in, w_step_out;
  logic [7:0]    w_rcon;

  assign w_accept = key_valid & key_ready;
`ifdef AES_KEY_CACHE_EN
  assign w_hit = (r_state == ST_DONE) && (key == r_rk[0]);
`else
  assign w_hit = 1'b0;
`endif
  assign w_start    = w_accept & ~w_hit;
  assign w_last     = (r_cnt == LAST);
  assign w_prev_idx = r_cnt - 4'd1;

  // Feed the step unit from the previous round key; zero outside the valid range.
  always_comb begin
    w_step_in = '0;
    w_rcon    = 8'h00;
    if (r_cnt >= 4'd1 && r_cnt <= LAST) begin
      w_step_in = r_rk[w_prev_idx];
      w_rcon    = RCON[r_cnt];
    end
  end

  aes_key_step u_step (
    .i_prev (w_step_in),
    .i_rcon (w_rcon),
    .o_next (w_step_out)
  );

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_start) w_state_nxt = ST_EXPAND;
      ST_EXPAND: if (w_last)  w_state_nxt = ST_DONE;
      ST_DONE:   if (w_start) w_state_nxt = ST_EXPAND;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    key_ready = (r_state != ST_EXPAND);
    busy      = (r_state == ST_EXPAND);
  end

  // Round counter, register file and schedule-valid flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt         <= '0;
      r_sched_valid <= 1'b0;
      for (int i = 0; i <= NROUNDS; i++) r_rk[i] <= '0;
    end else if (w_start) begin
      r_rk[0]       <= key;
      r_cnt         <= 4'd1;
      r_sched_valid <= 1'b0;
    end else if (r_state == ST_EXPAND) begin
      r_rk[r_cnt]   <= w_step_out;
      r_cnt         <= r_cnt + 4'd1;
      if (w_last) r_sched_valid <= 1'b1;
    end
  end

  assign sched_valid = r_sched_valid;

  // Indexed read; out-of-range indices read as zero.
  always_comb begin
    rk = '0;
    if (rk_idx <= LAST) rk = r_rk[rk_idx];
  end

  for (genvar g = 0; g <= NROUNDS; g++) begin : g_sched
    assign schedule[g*128 +: 128] = r_rk[g];
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboard bench for aes_key_sched_ctrl with an independent FIPS-197 model.
module tb_aes_key_sched_ctrl;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          key_valid = 1'b0;
  logic [127:0]  key = '0;
  logic          key_ready, busy, sched_valid;
  logic [3:0]    rk_idx = '0;
  logic [127:0]  rk;
  logic [1407:0] schedule;

  aes_key_sched_ctrl #(.NROUNDS(10)) dut (
    .clk(clk), .n_rst(n_rst), .key_valid(key_valid), .key(key),
    .key_ready(key_ready), .busy(busy), .sched_valid(sched_valid),
    .rk_idx(rk_idx), .rk(rk), .schedule(schedule)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { logic [127:0] k; int acc; } exp_t;
  exp_t q[$];

  logic [7:0] sb [0:255];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // GF(2^8) multiply with the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box from multiplicative inverse plus affine transform.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      if (a != 0)
        for (int x = 1; x < 256; x++)
          if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Word-oriented 44-word expansion, returned as 11 keys with key 0 in the MSBs.
  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    logic [1407:0] f;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) f[1407-32*i -: 32] = w[i];
    return f;
  endfunction

  // Monitor: on each sched_valid rise, pop the oldest expected key and check.
  logic prev_sv = 1'b0;
  always @(negedge clk) begin
    if (sched_valid && !prev_sv) begin
      if (q.size() == 0) begin
        chk("unexpected_sched_valid", 128'(sched_valid), 128'd0);
      end else begin
        exp_t e;
        logic [1407:0] m;
        e = q.pop_front();
        m = expand(e.k);
        chk("latency", 128'(cyc - e.acc), 128'd10);
        for (int r = 0; r <= 10; r++)
          chk($sformatf("schedule_rk%0d", r), schedule[1407-128*r -: 128], m[1407-128*r -: 128]);
      end
    end
    prev_sv = sched_valid;
  end

  task automatic accept(input logic [127:0] k, input bit push);
    @(negedge clk);
    key = k; key_valid = 1'b1;
    #1 chk("key_ready_on_accept", 128'(key_ready), 128'd1);
    @(posedge clk);
    #1;
    if (push) q.push_back('{k, cyc});
    key_valid = 1'b0;
  endtask

  task automatic wait_sched();
    int t = 0;
    while ((q.size() != 0 || !sched_valid) && t < 30) begin
      @(negedge clk); #2; t++;
    end
    if (t >= 30) begin
      n_cmp++; n_err++;
      $display("FAIL wait_sched timeout: got no schedule expected sched_valid within 30 cycles");
    end
  endtask

  task automatic read_rk(input string nm, input int idx, input logic [127:0] exp);
    rk_idx = 4'(idx);
    #1 chk(nm, rk, exp);
  endtask

  logic [127:0] fips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] k2   = 128'h000102030405060708090a0b0c0d0e0f;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] last_k, k;
    logic [1407:0] m;
    int nb, bad;
    build_sbox();

    // Reset state.
    #3;
    chk("rst_key_ready", 128'(key_ready), 128'd1);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_sched_valid", 128'(sched_valid), 128'd0);
    chk("rst_rk", rk, 128'd0);
    chk("rst_schedule_rk10", schedule[127:0], 128'd0);
    @(negedge clk) n_rst = 1'b1;

    // FIPS-197 key, with a rejected key presented mid-expansion.
    accept(fips, 1'b1);
    repeat (3) @(negedge clk);
    key = k2; key_valid = 1'b1;
    #1 chk("busy_key_ready", 128'(key_ready), 128'd0);
    chk("busy_busy", 128'(busy), 128'd1);
    @(negedge clk); key_valid = 1'b0;
    wait_sched();
    read_rk("fips_rk0", 0, fips);
    read_rk("fips_rk1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
    read_rk("fips_rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int i = 11; i < 16; i++) read_rk($sformatf("oob_rk%0d", i), i, 128'd0);
    chk("done_busy", 128'(busy), 128'd0);

    // Re-key from DONE.
    accept(k2, 1'b1);
    chk("rekey_sv_drop", 128'(sched_valid), 128'd0);
    chk("rekey_busy", 128'(busy), 128'd1);
    wait_sched();
    read_rk("k2_rk10", 10, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Reset mid-expansion.
    accept(128'({$urandom, $urandom, $urandom, $urandom}), 1'b1);
    repeat (5) @(negedge clk);
    #1 n_rst = 1'b0;
    q.delete();
    #1;
    chk("midrst_key_ready", 128'(key_ready), 128'd1);
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_sched_valid", 128'(sched_valid), 128'd0);
    for (int i = 0; i <= 10; i++) read_rk($sformatf("midrst_rk%0d", i), i, 128'd0);
    @(negedge clk) n_rst = 1'b1;
    last_k = 128'({$urandom, $urandom, $urandom, $urandom});
    accept(last_k, 1'b1);
    wait_sched();

    // Re-present the stored key from DONE.
`ifdef AES_KEY_CACHE_EN
    accept(last_k, 1'b0);
    bad = 0;
    repeat (12) begin
      @(negedge clk); #1;
      if (busy || !sched_valid) bad++;
    end
    chk("cache_hold_bad_cycles", 128'(bad), 128'd0);
`else
    accept(last_k, 1'b1);
    nb = 1;  // busy already high after the accept edge
    repeat (14) begin
      @(negedge clk); #1;
      if (busy) nb++;
    end
    chk("rekey_busy_cycles", 128'(nb - 1), 128'd10);
    wait_sched();
`endif

    // Randomized keys, idle gaps, intrusion attempts and indexed reads.
    for (int it = 0; it < 20; it++) begin
      bit hit;
      k = ($urandom_range(0, 3) == 0) ? last_k : 128'({$urandom, $urandom, $urandom, $urandom});
`ifdef AES_KEY_CACHE_EN
      hit = (k == last_k);
`else
      hit = 1'b0;
`endif
      repeat ($urandom_range(0, 3)) @(negedge clk);
      accept(k, !hit);
      if (!hit) begin
        repeat ($urandom_range(1, 7)) @(negedge clk);
        key = 128'({$urandom, $urandom, $urandom, $urandom}); key_valid = 1'b1;
        #1 chk("rand_intrude_key_ready", 128'(key_ready), 128'd0);
        @(posedge clk); #1 key_valid = 1'b0;
      end
      wait_sched();
      m = expand(k);
      begin
        int idx = $urandom_range(0, 15);
        read_rk($sformatf("rand_rk%0d", idx), idx, (idx <= 10) ? m[1407-128*idx -: 128] : 128'd0);
      end
      last_k = k;
    end

    chk("final_queue_empty", 128'(q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
